// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the SimpleRISC pipeline control slice.
//   pipeState_t   : control FSM states (RUN, WAIT, DRAIN, HALT, ERROR)
//   hazardCause_t : the single hazard that wins arbitration in a cycle
//   IF_STAGE/OF_STAGE : fixed indices of the fetch and operand-fetch stages
//   resolveHazard : priority encoder, highest priority first
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    WAIT,
    DRAIN,
    HALT,
    ERROR
  } pipeState_t;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_MEM_WAIT,
    HZ_DIV_BUSY,
    HZ_BRANCH,
    HZ_LOAD_USE
  } hazardCause_t;

  localparam int IF_STAGE = 0;
  localparam int OF_STAGE = 1;

  // Memory wait beats the divider, both beat a taken branch (a held EX
  // cannot redirect), and a taken branch squashes the load-use victim so
  // the load-use stall is dropped entirely.
  function automatic hazardCause_t resolveHazard(
    input logic memWait,
    input logic divStall,
    input logic branchTaken,
    input logic loadUse
  );
    if (memWait)     return HZ_MEM_WAIT;
    if (divStall)    return HZ_DIV_BUSY;
    if (branchTaken) return HZ_BRANCH;
    if (loadUse)     return HZ_LOAD_USE;
    return HZ_NONE;
  endfunction

endpackage

// File: rtl/pipe_mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// pipe_mem_wait_fsm
// Pipeline control FSM: tracks memory waits with a timeout counter, the
// halt drain sequence, and the terminal HALT/ERROR states.
// Ports:
//   clk, rst          core clock, async active-high reset
//   mem_wait_i        valid MEM access is waiting on data memory this cycle
//   stop_accept_i     halt instruction in OF advances this cycle
//   pipe_empty_i      every stage valid bit is clear
//   state_o           current FSM state
//   halt_pending_o    halt accepted, fetch must stay blocked
//   mem_timeout_o     sticky: a memory wait ran past MEM_TIMEOUT
//   halted_o          pipeline drained after a halt
// ---------------------------------------------------------------------------
module pipe_mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_wait_i,
  input  logic       stop_accept_i,
  input  logic       pipe_empty_i,
  output pipeState_t state_o,
  output logic       halt_pending_o,
  output logic       mem_timeout_o,
  output logic       halted_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  pipeState_t        state_q;
  logic [WAIT_W-1:0] waitCnt_q;
  logic              haltPending_q;
  logic              memTimeout_q;
  logic              halted_q;

  // The counter is loaded with 1 on the cycle the wait is first seen, so a
  // done arriving while the counter equals MEM_TIMEOUT still succeeds; only
  // a further miss in that cycle enters ERROR. A halt accepted in the same
  // cycle the wait ends is not lost: the exit goes straight to DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      waitCnt_q     <= '0;
      haltPending_q <= 1'b0;
      memTimeout_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stop_accept_i) begin
            state_q       <= DRAIN;
            haltPending_q <= 1'b1;
          end else if (mem_wait_i) begin
            state_q   <= WAIT;
            waitCnt_q <= WAIT_W'(1);
          end
        end
        WAIT: begin
          if (!mem_wait_i) begin
            state_q       <= (haltPending_q || stop_accept_i) ? DRAIN : RUN;
            haltPending_q <= haltPending_q | stop_accept_i;
            waitCnt_q     <= '0;
          end else if (waitCnt_q == TIMEOUT_VAL) begin
            state_q      <= ERROR;
            memTimeout_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + WAIT_W'(1);
          end
        end
        DRAIN: begin
          if (pipe_empty_i) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (mem_wait_i) begin
            state_q   <= WAIT;
            waitCnt_q <= WAIT_W'(1);
          end
        end
        HALT:    state_q <= HALT;
        ERROR:   state_q <= ERROR;
        default: state_q <= RUN;
      endcase
    end
  end

  assign state_o        = state_q;
  assign halt_pending_o = haltPending_q;
  assign mem_timeout_o  = memTimeout_q;
  assign halted_o       = halted_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Parametrised stall/flush control for the SimpleRISC pipeline. Tracks a
// valid bit per stage and turns memory wait, divider busy, load-use and
// taken-branch events into per-stage hold/bubble strobes.
// Ports:
//   clk, rst                 core clock, async active-high reset
//   fetch_valid_i            IF has a real instruction
//   stop_i                   halt opcode decoded in OF
//   of_rs1_i/of_rs2_i        OF source registers, of_use1_i/of_use2_i gate them
//   ex_is_ld_i, ex_rd_i      EX holds a load writing ex_rd_i
//   div_busy_i               multicycle ALU op in EX still running
//   branch_taken_i           EX resolved a taken branch
//   mem_req_i, mem_done_i    MEM access present / completing
//   hold_o[i]                pipe register feeding stage i keeps its value
//   bubble_o[i]              pipe register feeding stage i loads a NOP
//   stage_valid_o            registered valid bit per stage
//   mem_timeout_o, halted_o  sticky status
// Optional build macro PIPE_PERF_EN adds stall_cycles_o, flush_count_o and
// bubble_count_o saturating counters (width CNT_W).
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int EX_STAGE    = 2,
  parameter int MEM_STAGE   = 3,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
`ifdef PIPE_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid_i,
  input  logic                  stop_i,
  input  logic [REG_AW-1:0]     of_rs1_i,
  input  logic [REG_AW-1:0]     of_rs2_i,
  input  logic                  of_use1_i,
  input  logic                  of_use2_i,
  input  logic                  ex_is_ld_i,
  input  logic [REG_AW-1:0]     ex_rd_i,
  input  logic                  div_busy_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_done_i,
  output logic [NUM_STAGES-1:0] hold_o,
  output logic [NUM_STAGES-1:0] bubble_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic                  mem_timeout_o,
  output logic                  halted_o
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_count_o,
  output logic [CNT_W-1:0]      bubble_count_o
`endif
);

  logic [NUM_STAGES-1:0] stageValid_q;
  logic [NUM_STAGES-1:0] stageValid_d;
  logic [NUM_STAGES-1:0] prevValid;
  logic [NUM_STAGES-1:0] holdMask;
  logic [NUM_STAGES-1:0] bubbleMask;
  logic                  memWait;
  logic                  divStall;
  logic                  srcHit;
  logic                  loadUse;
  logic                  frozen;
  logic                  stopAccept;
  logic                  fetchIn;
  logic                  pipeEmpty;
  logic                  haltPending;
  hazardCause_t          cause;
  pipeState_t            state;

  // Raw hazard conditions; r0 is hardwired zero so it never creates a
  // load-use dependency.
  assign memWait  = mem_req_i & stageValid_q[MEM_STAGE] & ~mem_done_i;
  assign divStall = div_busy_i & stageValid_q[EX_STAGE];
  assign srcHit   = (of_use1_i && (of_rs1_i == ex_rd_i)) ||
                    (of_use2_i && (of_rs2_i == ex_rd_i));
  assign loadUse  = ex_is_ld_i & stageValid_q[EX_STAGE] & (ex_rd_i != '0) & srcHit;

  assign frozen = (state == HALT) || (state == ERROR);
  assign cause  = frozen ? HZ_NONE
                         : resolveHazard(memWait, divStall, branch_taken_i, loadUse);

  // Hold/bubble masks for the winning hazard. Everything is forced low
  // while reset is asserted so the pipe registers see a quiet interface,
  // and HALT/ERROR freeze every stage.
  always_comb begin
    holdMask   = '0;
    bubbleMask = '0;
    if (!rst) begin
      if (frozen) begin
        holdMask = '1;
      end else begin
        case (cause)
          HZ_MEM_WAIT: begin
            for (int i = 0; i <= MEM_STAGE; i++) holdMask[i] = 1'b1;
            bubbleMask[MEM_STAGE+1] = 1'b1;
          end
          HZ_DIV_BUSY: begin
            for (int i = 0; i <= EX_STAGE; i++) holdMask[i] = 1'b1;
            bubbleMask[EX_STAGE+1] = 1'b1;
          end
          HZ_BRANCH: begin
            for (int i = OF_STAGE; i <= EX_STAGE; i++) bubbleMask[i] = 1'b1;
          end
          HZ_LOAD_USE: begin
            holdMask[IF_STAGE]   = 1'b1;
            holdMask[OF_STAGE]   = 1'b1;
            bubbleMask[EX_STAGE] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign hold_o   = holdMask;
  assign bubble_o = bubbleMask;

  // Fetch is blocked from the very cycle the halt is accepted, so nothing
  // younger than the halt enters the pipe.
  assign stopAccept = stop_i & stageValid_q[OF_STAGE] & ~holdMask[OF_STAGE];
  assign fetchIn    = fetch_valid_i & ~(haltPending | stopAccept);
  assign prevValid  = {stageValid_q[NUM_STAGES-2:0], fetchIn};
  assign pipeEmpty  = (stageValid_q == '0);

  // Valid chain: a held stage keeps its bit, otherwise it takes the bit of
  // the stage behind it unless that register is being bubbled.
  always_comb begin
    stageValid_d = stageValid_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (!holdMask[i]) stageValid_d[i] = bubbleMask[i] ? 1'b0 : prevValid[i];
    end
  end

  // Stage valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stageValid_q <= '0;
    else     stageValid_q <= stageValid_d;
  end

  assign stage_valid_o = stageValid_q;

  pipe_mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_fsm (
    .clk            (clk),
    .rst            (rst),
    .mem_wait_i     (memWait),
    .stop_accept_i  (stopAccept),
    .pipe_empty_i   (pipeEmpty),
    .state_o        (state),
    .halt_pending_o (haltPending),
    .mem_timeout_o  (mem_timeout_o),
    .halted_o       (halted_o)
  );

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stallCycles_q;
  logic [CNT_W-1:0] flushCount_q;
  logic [CNT_W-1:0] bubbleCount_q;

  // Saturating event counters; they stop moving once the pipe is frozen
  // so the final values describe the run up to the halt or error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
      bubbleCount_q <= '0;
    end else if (!frozen) begin
      if (holdMask[IF_STAGE] && (stallCycles_q != '1))
        stallCycles_q <= stallCycles_q + CNT_W'(1);
      if ((cause == HZ_BRANCH) && (flushCount_q != '1))
        flushCount_q <= flushCount_q + CNT_W'(1);
      if ((cause == HZ_LOAD_USE) && (bubbleCount_q != '1))
        bubbleCount_q <= bubbleCount_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stallCycles_q;
  assign flush_count_o  = flushCount_q;
  assign bubble_count_o = bubbleCount_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with the default parameters
// (5 stages, EX=2, MEM=3, MEM_TIMEOUT=15). Expected values are worked out
// by hand from the valid-chain and hazard-priority rules. Counter checks
// are compiled in when PIPE_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       fetchValid;
    logic       stop;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       exIsLd;
    logic [4:0] exRd;
    logic       divBusy;
    logic       branchTaken;
    logic       memReq;
    logic       memDone;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fetchValid, stop, use1, use2, exIsLd, divBusy, branchTaken, memReq, memDone;
  logic [4:0] rs1, rs2, exRd;
  logic [4:0] hold, bubble, stageValid;
  logic       memTimeout, halted;
`ifdef PIPE_PERF_EN
  logic [31:0] stallCycles, flushCount, bubbleCount;
`endif

  int    testsRun    = 0;
  int    testsFailed = 0;
  stim_t s;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid_i  (fetchValid),
    .stop_i         (stop),
    .of_rs1_i       (rs1),
    .of_rs2_i       (rs2),
    .of_use1_i      (use1),
    .of_use2_i      (use2),
    .ex_is_ld_i     (exIsLd),
    .ex_rd_i        (exRd),
    .div_busy_i     (divBusy),
    .branch_taken_i (branchTaken),
    .mem_req_i      (memReq),
    .mem_done_i     (memDone),
    .hold_o         (hold),
    .bubble_o       (bubble),
    .stage_valid_o  (stageValid),
    .mem_timeout_o  (memTimeout),
    .halted_o       (halted)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles_o (stallCycles),
    .flush_count_o  (flushCount),
    .bubble_count_o (bubbleCount)
`endif
  );

  task automatic applyStimulus(input stim_t v);
    fetchValid  = v.fetchValid;
    stop        = v.stop;
    rs1         = v.rs1;
    rs2         = v.rs2;
    use1        = v.use1;
    use2        = v.use2;
    exIsLd      = v.exIsLd;
    exRd        = v.exRd;
    divBusy     = v.divBusy;
    branchTaken = v.branchTaken;
    memReq      = v.memReq;
    memDone     = v.memDone;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a further unit later, far from the next edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    s = '0;
    applyStimulus(s);
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic fillPipe(input int n);
    s = '0;
    s.fetchValid = 1'b1;
    applyStimulus(s);
    repeat (n) nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, with noisy inputs that must not leak through.
    s = '0;
    s.branchTaken = 1'b1;
    s.divBusy     = 1'b1;
    applyStimulus(s);
    rst = 1'b1;
    nextCycle();
    checkOutput("reset_hold", 32'(hold), 32'h00);
    checkOutput("reset_bubble", 32'(bubble), 32'h00);
    checkOutput("reset_valid", 32'(stageValid), 32'h00);
    checkOutput("reset_timeout", 32'(memTimeout), 32'h0);
    checkOutput("reset_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    #1;

    // Load-use: ld r3 in EX, OF reads r3.
    doReset();
    fillPipe(3);
    checkOutput("lu_fill_valid", 32'(stageValid), 32'h07);
    s = '0;
    s.fetchValid = 1'b1; s.exIsLd = 1'b1; s.exRd = 5'd3; s.rs1 = 5'd3; s.use1 = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lu_hold", 32'(hold), 32'h03);
    checkOutput("lu_bubble", 32'(bubble), 32'h04);
    nextCycle();
    checkOutput("lu_valid_after", 32'(stageValid), 32'h0B);
    checkOutput("lu_one_cycle_hold", 32'(hold), 32'h00);
    checkOutput("lu_one_cycle_bubble", 32'(bubble), 32'h00);
    nextCycle();
    checkOutput("lu_valid_refill", 32'(stageValid), 32'h17);
    s.exRd = 5'd0; s.rs1 = 5'd0;
    applyStimulus(s);
    #1;
    checkOutput("lu_r0_no_stall", 32'(hold), 32'h00);
    s.exRd = 5'd5; s.rs1 = 5'd1; s.use1 = 1'b1; s.rs2 = 5'd5; s.use2 = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lu_rs2_hold", 32'(hold), 32'h03);
    s.use2 = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("lu_rs2_unused", 32'(hold), 32'h00);
    nextCycle();
`ifdef PIPE_PERF_EN
    checkOutput("lu_perf_stall", stallCycles, 32'd1);
    checkOutput("lu_perf_bubble", bubbleCount, 32'd1);
    checkOutput("lu_perf_flush", flushCount, 32'd0);
`endif

    // Memory wait, done after 4 waiting cycles.
    doReset();
    fillPipe(4);
    checkOutput("mw_fill_valid", 32'(stageValid), 32'h0F);
    s = '0;
    s.fetchValid = 1'b1; s.memReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s);
      #1;
      checkOutput($sformatf("mw_hold_%0d", i), 32'(hold), 32'h0F);
      checkOutput($sformatf("mw_bubble_%0d", i), 32'(bubble), 32'h10);
      nextCycle();
    end
    s.memDone = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("mw_done_hold", 32'(hold), 32'h00);
    nextCycle();
    checkOutput("mw_no_lost", 32'(stageValid), 32'h1F);
    #1;
    checkOutput("mw_same_cycle_done", 32'(hold), 32'h00);
    nextCycle();
    checkOutput("mw_timeout_clear", 32'(memTimeout), 32'h0);

    // Timeout: done never arrives.
    doReset();
    fillPipe(4);
    s = '0;
    s.fetchValid = 1'b1; s.memReq = 1'b1;
    applyStimulus(s);
    repeat (15) nextCycle();
    checkOutput("to_before_timeout", 32'(memTimeout), 32'h0);
    checkOutput("to_still_waiting", 32'(hold), 32'h0F);
    nextCycle();
    checkOutput("to_timeout_set", 32'(memTimeout), 32'h1);
    s.memReq = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("to_freeze_hold", 32'(hold), 32'h1F);
    checkOutput("to_freeze_bubble", 32'(bubble), 32'h00);
    repeat (3) nextCycle();
    checkOutput("to_sticky", 32'(memTimeout), 32'h1);
    checkOutput("to_valid_frozen", 32'(stageValid), 32'h0F);
    doReset();
    checkOutput("to_reset_clears", 32'(memTimeout), 32'h0);

    // Done arriving in the timeout cycle counts as success.
    fillPipe(4);
    s = '0;
    s.fetchValid = 1'b1; s.memReq = 1'b1;
    applyStimulus(s);
    repeat (15) nextCycle();
    s.memDone = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("tl_done_hold", 32'(hold), 32'h00);
    nextCycle();
    s = '0;
    applyStimulus(s);
    nextCycle();
    checkOutput("tl_no_timeout", 32'(memTimeout), 32'h0);

    // Branch and load-use in the same cycle.
    doReset();
    fillPipe(3);
    s = '0;
    s.fetchValid = 1'b1; s.branchTaken = 1'b1;
    s.exIsLd = 1'b1; s.exRd = 5'd3; s.rs1 = 5'd3; s.use1 = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("bl_hold", 32'(hold), 32'h00);
    checkOutput("bl_bubble", 32'(bubble), 32'h06);
    nextCycle();
    checkOutput("bl_valid", 32'(stageValid), 32'h09);

    // div_busy for 8 cycles with a pending taken branch.
    doReset();
    fillPipe(3);
    s = '0;
    s.fetchValid = 1'b1; s.divBusy = 1'b1; s.branchTaken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s);
      #1;
      checkOutput($sformatf("div_hold_%0d", i), 32'(hold), 32'h07);
      checkOutput($sformatf("div_bubble_%0d", i), 32'(bubble), 32'h08);
      nextCycle();
    end
    s.divBusy = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("div_branch_hold", 32'(hold), 32'h00);
    checkOutput("div_branch_bubble", 32'(bubble), 32'h06);
    nextCycle();
    checkOutput("div_branch_valid", 32'(stageValid), 32'h09);
    s.branchTaken = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("div_after_bubble", 32'(bubble), 32'h00);
    nextCycle();
`ifdef PIPE_PERF_EN
    checkOutput("div_perf_stall", stallCycles, 32'd8);
    checkOutput("div_perf_flush", flushCount, 32'd1);
    checkOutput("div_perf_bubble", bubbleCount, 32'd0);
`endif

    // Halt in OF with EX, MEM and WB occupied.
    doReset();
    fillPipe(4);
    s = '0;
    applyStimulus(s);
    nextCycle();
    checkOutput("halt_setup_valid", 32'(stageValid), 32'h1E);
    s.stop = 1'b1; s.fetchValid = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("halt_accept_hold", 32'(hold), 32'h00);
    nextCycle();
    checkOutput("halt_fetch_blocked", 32'(stageValid), 32'h1C);
    checkOutput("halt_not_yet_0", 32'(halted), 32'h0);
    s.stop = 1'b0;
    applyStimulus(s);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      checkOutput($sformatf("halt_not_yet_%0d", i), 32'(halted), 32'h0);
    end
    checkOutput("halt_drained", 32'(stageValid), 32'h00);
    nextCycle();
    checkOutput("halt_rises", 32'(halted), 32'h1);
    #1;
    checkOutput("halt_hold_all", 32'(hold), 32'h1F);
    nextCycle();
    checkOutput("halt_stays_empty", 32'(stageValid), 32'h00);
    checkOutput("halt_sticky", 32'(halted), 32'h1);
`ifdef PIPE_PERF_EN
    checkOutput("halt_perf_frozen", stallCycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
